// File: rtl/fp_arb_pkg.sv
// Shared types and defaults for the floating-point unit arbiter.
package fp_arb_pkg;

  // Requester count used when the arbiter is instantiated without overrides.
  localparam int ARB_DEFAULT_NUM_REQ = 3;

  // ARB picks a winner, ISSUE holds the unit start pulse, WAIT waits for the result.
  typedef enum logic [1:0] {
    ARB,
    ISSUE,
    WAIT
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: finds the first set pending bit at or after
// the pointer, wrapping around, using a doubled copy of the pending vector so
// the wrap needs no special case.
module rr_priority_picker #(
  parameter int NUM_REQ  = 3,
  parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  pending,
  input  logic [REQ_ID_W-1:0] pointer,
  output logic [REQ_ID_W-1:0] winner,
  output logic                found
);

  logic [2*NUM_REQ-1:0] doubled;
  int                   offset;
  int                   sum;

  assign doubled = {pending, pending};

  // Scan NUM_REQ positions of the doubled vector starting at the pointer;
  // the first hit is the winner, expressed as an offset from the pointer.
  always_comb begin
    found  = 1'b0;
    offset = 0;
    sum    = 0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && doubled[int'(pointer) + k]) begin
        found  = 1'b1;
        offset = k;
      end
    end
    sum = int'(pointer) + offset;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    winner = REQ_ID_W'(sum);
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one floating-point unit between several requester engines.
// Each start pulse is captured with its operands into a per-requester slot;
// slots are issued to the unit one at a time in round-robin order and each
// result is routed back to the requester that issued it.
module fp_unit_arbiter
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ    = ARB_DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = 32,
  parameter int REQ_ID_W   = $clog2(NUM_REQ)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_start,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_operand_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_operand_b,
  output logic [NUM_REQ-1:0]                 req_result_ready,
  output logic [DATA_WIDTH-1:0]              req_result,
  output logic                               unit_start,
  output logic [DATA_WIDTH-1:0]              unit_operand_a,
  output logic [DATA_WIDTH-1:0]              unit_operand_b,
  input  logic                               unit_result_ready,
  input  logic [DATA_WIDTH-1:0]              unit_result,
  output logic                               busy,
  output logic [REQ_ID_W-1:0]                grant_id,
  output logic [NUM_REQ-1:0]                 overflow_err
);

  arb_state_t            state;
  arb_state_t            next_state;

  logic [NUM_REQ-1:0]    pending;
  logic [DATA_WIDTH-1:0] op_a_q [NUM_REQ];
  logic [DATA_WIDTH-1:0] op_b_q [NUM_REQ];
  logic [REQ_ID_W-1:0]   pointer;

  logic [REQ_ID_W-1:0]   win_id;
  logic                  win_found;
  logic                  grant_fire;
  logic [NUM_REQ-1:0]    grant_vec;
  logic                  result_take;
  logic [NUM_REQ-1:0]    result_onehot;
  logic [REQ_ID_W-1:0]   pointer_next;

  rr_priority_picker #(
    .NUM_REQ  (NUM_REQ),
    .REQ_ID_W (REQ_ID_W)
  ) u_picker (
    .pending (pending),
    .pointer (pointer),
    .winner  (win_id),
    .found   (win_found)
  );

  // A grant happens only from ARB and only when some slot is pending; the
  // result is only accepted while an operation is actually outstanding.
  assign grant_fire    = (state == ARB) && win_found;
  assign grant_vec     = grant_fire ? (NUM_REQ'(1) << win_id) : '0;
  assign result_take   = (state == WAIT) && unit_result_ready;
  assign result_onehot = NUM_REQ'(1) << grant_id;
  assign pointer_next  = (grant_id == REQ_ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // Busy covers both an operation in flight and work still queued.
  assign busy = (state != ARB) || (|pending);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ARB;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one operation at a time, waiting indefinitely for the unit.
  always_comb begin
    next_state = state;
    case (state)
      ARB:     if (win_found) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    if (unit_result_ready) next_state = ARB;
      default: next_state = ARB;
    endcase
  end

  // Capture start pulses into the per-requester slots. A start on the edge
  // its own slot is granted refills the slot; a start on a slot that stays
  // occupied is dropped and flagged until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending      <= '0;
      overflow_err <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        op_a_q[i] <= '0;
        op_b_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_start[i]) begin
          if (!pending[i] || grant_vec[i]) begin
            pending[i] <= 1'b1;
            op_a_q[i]  <= req_operand_a[i];
            op_b_q[i]  <= req_operand_b[i];
          end else begin
            overflow_err[i] <= 1'b1;
          end
        end else if (grant_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  // Drive the unit on a grant and return its result to the granted requester,
  // advancing the round-robin pointer past the requester just served.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      unit_start       <= 1'b0;
      unit_operand_a   <= '0;
      unit_operand_b   <= '0;
      grant_id         <= '0;
      req_result_ready <= '0;
      req_result       <= '0;
      pointer          <= '0;
    end else begin
      unit_start       <= grant_fire;
      req_result_ready <= '0;
      if (grant_fire) begin
        grant_id       <= win_id;
        unit_operand_a <= op_a_q[win_id];
        unit_operand_b <= op_b_q[win_id];
      end
      if (result_take) begin
        req_result_ready <= result_onehot;
        req_result       <= unit_result;
        pointer          <= pointer_next;
      end
    end
  end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Testbench for fp_unit_arbiter: a transaction-level model of the arbiter is
// compared against the DUT every cycle, a mock FP unit answers issued
// operations, and directed scenarios pin specific grant orders and values.
module tb_fp_unit_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [N-1:0]         req_start = '0;
  logic [N-1:0][DW-1:0] req_operand_a = '0;
  logic [N-1:0][DW-1:0] req_operand_b = '0;
  logic [N-1:0]         req_result_ready;
  logic [DW-1:0]        req_result;
  logic                 unit_start;
  logic [DW-1:0]        unit_operand_a;
  logic [DW-1:0]        unit_operand_b;
  logic                 unit_result_ready = 1'b0;
  logic [DW-1:0]        unit_result = '0;
  logic                 busy;
  logic [IW-1:0]        grant_id;
  logic [N-1:0]         overflow_err;

  int total = 0;
  int bad   = 0;

  fp_unit_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .REQ_ID_W   (IW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_start         (req_start),
    .req_operand_a     (req_operand_a),
    .req_operand_b     (req_operand_b),
    .req_result_ready  (req_result_ready),
    .req_result        (req_result),
    .unit_start        (unit_start),
    .unit_operand_a    (unit_operand_a),
    .unit_operand_b    (unit_operand_b),
    .unit_result_ready (unit_result_ready),
    .unit_result       (unit_result),
    .busy              (busy),
    .grant_id          (grant_id),
    .overflow_err      (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: queued slots per requester, a pointer, and a phase
  // (0 = idle/choosing, 1 = start pulse out, 2 = waiting for the unit).
  logic [N-1:0]  m_pend = '0;
  logic [DW-1:0] m_opa [N];
  logic [DW-1:0] m_opb [N];
  int            m_ptr = 0;
  int            m_phase = 0;
  int            m_gid = 0;
  logic          e_ustart = 1'b0;
  logic [DW-1:0] e_ua = '0;
  logic [DW-1:0] e_ub = '0;
  logic [DW-1:0] e_res = '0;
  logic [N-1:0]  e_rdy = '0;
  logic [N-1:0]  e_ovf = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pend = '0; m_ptr = 0; m_phase = 0; m_gid = 0;
      e_ustart = 1'b0; e_ua = '0; e_ub = '0; e_res = '0; e_rdy = '0; e_ovf = '0;
      for (int i = 0; i < N; i++) begin
        m_opa[i] = '0;
        m_opb[i] = '0;
      end
    end else begin
      int g;
      g = -1;
      if (m_phase == 0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (g < 0 && m_pend[idx]) g = idx;
        end
      end
      e_rdy = '0;
      if (m_phase == 2 && unit_result_ready) begin
        e_rdy   = N'(1) << m_gid;
        e_res   = unit_result;
        m_ptr   = (m_gid + 1) % N;
        m_phase = 0;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end
      e_ustart = (g >= 0);
      if (g >= 0) begin
        e_ua      = m_opa[g];
        e_ub      = m_opb[g];
        m_gid     = g;
        m_pend[g] = 1'b0;
        m_phase   = 1;
      end
      for (int i = 0; i < N; i++) begin
        if (req_start[i]) begin
          if (m_pend[i]) begin
            e_ovf[i] = 1'b1;
          end else begin
            m_pend[i] = 1'b1;
            m_opa[i]  = req_operand_a[i];
            m_opb[i]  = req_operand_b[i];
          end
        end
      end
    end
  end

  // Log of issued operations as seen on the unit side.
  int            glog_id [$];
  logic [DW-1:0] glog_a [$];

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clock) begin
    checkOutput("unit_start", unit_start, e_ustart);
    checkOutput("unit_operand_a", unit_operand_a, e_ua);
    checkOutput("unit_operand_b", unit_operand_b, e_ub);
    checkOutput("grant_id", grant_id, m_gid);
    checkOutput("req_result_ready", req_result_ready, e_rdy);
    checkOutput("req_result", req_result, e_res);
    checkOutput("busy", busy, (m_phase != 0) || (|m_pend));
    checkOutput("overflow_err", overflow_err, e_ovf);
    if (unit_start) begin
      glog_id.push_back(int'(grant_id));
      glog_a.push_back(unit_operand_a);
    end
  end

  // Mock FP unit: answers each issued operation after a programmable delay,
  // optionally with a fixed result, and can emit spurious result pulses.
  int            mock_cnt = 0;
  logic [DW-1:0] mock_res = '0;
  bit            fixed_en = 1'b0;
  logic [DW-1:0] fixed_val = '0;
  int            delay_lo = 1;
  int            delay_hi = 5;
  bit            spur_en = 1'b0;

  always @(negedge clock) begin
    #1;
    unit_result_ready = 1'b0;
    if (unit_start) begin
      mock_cnt = $urandom_range(delay_hi, delay_lo);
      mock_res = fixed_en ? fixed_val : unit_operand_a + unit_operand_b;
    end else if (mock_cnt > 0) begin
      mock_cnt--;
      if (mock_cnt == 0) begin
        unit_result_ready = 1'b1;
        unit_result       = mock_res;
      end
    end else if (spur_en && $urandom_range(15, 0) == 0) begin
      unit_result_ready = 1'b1;
      unit_result       = $urandom;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Drives one start pulse (one cycle) with the given operands.
  task automatic applyStimulus(input logic [N-1:0] st, input logic [N-1:0][DW-1:0] a,
                               input logic [N-1:0][DW-1:0] b);
    req_start     = st;
    req_operand_a = a;
    req_operand_b = b;
    tick();
    req_start = '0;
  endtask

  task automatic waitIdle(input string name, input int maxc);
    int c;
    c = 0;
    while (!(m_phase == 0 && m_pend == '0 && mock_cnt == 0) && c < maxc) begin
      tick();
      c++;
    end
    tick();
    if (c >= maxc) begin
      total++;
      bad++;
      $display("[TB] FAIL %s timeout actual=%0d cycles required<%0d", name, c, maxc);
    end
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  logic [N-1:0][DW-1:0] va, vb;

  initial begin
    va = '0;
    vb = '0;
    repeat (3) tick();
    checkOutput("rst_unit_start", unit_start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", req_result_ready, 0);
    checkOutput("rst_overflow", overflow_err, 0);
    checkOutput("rst_operand_a", unit_operand_a, 0);
    reset = 1'b1;
    tick();

    // Single request from requester 1 with a fixed unit latency.
    fixed_en = 1'b1; fixed_val = 32'h4040_0000; delay_lo = 4; delay_hi = 4;
    va = '0; vb = '0;
    va[1] = 32'h3F80_0000; vb[1] = 32'h4000_0000;
    req_start = 3'b010; req_operand_a = va; req_operand_b = vb;
    tick();
    req_start = '0;
    checkOutput("t1_no_early_start", unit_start, 0);
    tick();
    checkOutput("t1_unit_start", unit_start, 1);
    checkOutput("t1_operand_a", unit_operand_a, 32'h3F80_0000);
    checkOutput("t1_operand_b", unit_operand_b, 32'h4000_0000);
    checkOutput("t1_grant_id", grant_id, 1);
    begin
      int c;
      c = 0;
      while (req_result_ready == '0 && c < 20) begin
        tick();
        c++;
      end
      checkOutput("t1_ready", req_result_ready, 3'b010);
      checkOutput("t1_result", req_result, 32'h4040_0000);
      checkOutput("t1_model_result", e_res, 32'h4040_0000);
      checkOutput("t1_busy_falls", busy, 0);
    end
    tick();
    checkOutput("t1_ready_one_cycle", req_result_ready, 0);
    fixed_en = 1'b0; delay_lo = 1; delay_hi = 5;

    // Contention from a freshly reset pointer.
    pulseReset();
    glog_id.delete(); glog_a.delete();
    for (int i = 0; i < N; i++) begin
      va[i] = 32'h1000_0000 * (i + 1);
      vb[i] = i + 7;
    end
    applyStimulus(3'b111, va, vb);
    waitIdle("t2_idle", 100);
    checkOutput("t2_count", glog_id.size(), 3);
    if (glog_id.size() == 3) begin
      for (int i = 0; i < N; i++) begin
        checkOutput("t2_order", glog_id[i], i);
        checkOutput("t2_operand", glog_a[i], 32'h1000_0000 * (i + 1));
      end
    end
    glog_id.delete(); glog_a.delete();
    applyStimulus(3'b101, va, vb);
    waitIdle("t2_wrap_idle", 100);
    checkOutput("t2_wrap_count", glog_id.size(), 2);
    if (glog_id.size() == 2) begin
      checkOutput("t2_ptr_wrap_first", glog_id[0], 0);
      checkOutput("t2_ptr_wrap_second", glog_id[1], 2);
    end

    // Rotation: after requester 1 is served, requester 2 goes before 0.
    applyStimulus(3'b010, va, vb);
    waitIdle("t3_idle_a", 100);
    glog_id.delete(); glog_a.delete();
    applyStimulus(3'b101, va, vb);
    waitIdle("t3_idle_b", 100);
    checkOutput("t3_count", glog_id.size(), 2);
    if (glog_id.size() == 2) begin
      checkOutput("t3_first", glog_id[0], 2);
      checkOutput("t3_second", glog_id[1], 0);
    end

    // Overflow: requester 0 starts twice while the unit is busy with requester 1.
    delay_lo = 6; delay_hi = 6;
    glog_id.delete(); glog_a.delete();
    applyStimulus(3'b010, va, vb);
    tick();
    va[0] = 32'hAAAA_0001;
    applyStimulus(3'b001, va, vb);
    va[0] = 32'hBBBB_0002;
    applyStimulus(3'b001, va, vb);
    checkOutput("t4_overflow", overflow_err, 3'b001);
    waitIdle("t4_idle", 100);
    begin
      int n0;
      n0 = 0;
      for (int i = 0; i < glog_id.size(); i++) begin
        if (glog_id[i] == 0) begin
          n0++;
          checkOutput("t4_first_operands_issued", glog_a[i], 32'hAAAA_0001);
        end
      end
      checkOutput("t4_single_issue", n0, 1);
    end

    // Same-edge re-request from requester 2.
    delay_lo = 1; delay_hi = 5;
    glog_id.delete(); glog_a.delete();
    va[2] = 32'h2222_0001;
    applyStimulus(3'b100, va, vb);
    va[2] = 32'h2222_0002;
    applyStimulus(3'b100, va, vb);
    waitIdle("t5_idle", 100);
    checkOutput("t5_count", glog_id.size(), 2);
    if (glog_id.size() == 2) begin
      checkOutput("t5_id_a", glog_id[0], 2);
      checkOutput("t5_id_b", glog_id[1], 2);
      checkOutput("t5_op_a", glog_a[0], 32'h2222_0001);
      checkOutput("t5_op_b", glog_a[1], 32'h2222_0002);
    end
    checkOutput("t5_no_overflow", overflow_err[2], 0);

    // Reset while waiting; the late unit result must be ignored.
    delay_lo = 8; delay_hi = 8;
    applyStimulus(3'b001, va, vb);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("t6_no_ready", req_result_ready, 0);
      checkOutput("t6_busy", busy, 0);
      checkOutput("t6_unit_start", unit_start, 0);
      checkOutput("t6_result", req_result, 0);
      checkOutput("t6_overflow", overflow_err, 0);
    end

    // Randomized traffic with spurious unit pulses.
    delay_lo = 1; delay_hi = 5; spur_en = 1'b1;
    pulseReset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        req_start[i]     = ($urandom_range(3, 0) == 0);
        req_operand_a[i] = $urandom;
        req_operand_b[i] = $urandom;
      end
      tick();
    end
    req_start = '0;
    spur_en = 1'b0;
    waitIdle("rand_idle", 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Shares one floating-point arithmetic unit (adder, multiplier, exponent or divider) between NUM_REQ requesters, for example the angle_combination, angle_normalization and term_accumulator engines.
- Replaces static state-based operand muxing with dynamic round-robin arbitration, so requesters can run concurrently.
- Captures each one-cycle start pulse and its operands, issues operations to the unit one at a time, and returns each result to the requester that issued it.
- Sits between the requester engines and a single FP unit instance inside the expression evaluator.

Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- DATA_WIDTH, 32: operand and result width (IEEE-754 single).
- REQ_ID_W, $clog2(NUM_REQ): width of the requester index.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_start  in  NUM_REQ  per-requester one-cycle start pulse.
- req_operand_a  in  NUM_REQ x DATA_WIDTH  operand A per requester, valid while req_start is high.
- req_operand_b  in  NUM_REQ x DATA_WIDTH  operand B per requester, valid while req_start is high.
- req_result_ready  out  NUM_REQ  one-hot one-cycle pulse: result for this requester is valid.
- req_result  out  DATA_WIDTH  result bus shared by all requesters; qualified by req_result_ready.
- unit_start  out  1  one-cycle start pulse to the FP unit.
- unit_operand_a  out  DATA_WIDTH  operand A to the FP unit.
- unit_operand_b  out  DATA_WIDTH  operand B to the FP unit.
- unit_result_ready  in  1  FP unit result-valid pulse.
- unit_result  in  DATA_WIDTH  FP unit result.
- busy  out  1  high while an operation is in flight or any request is pending.
- grant_id  out  REQ_ID_W  index of the requester currently owning the unit.
- overflow_err  out  NUM_REQ  sticky flag per requester: a start arrived while that requester already had a pending request.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0; state is ARB; every pending flag is cleared; the round-robin pointer is 0; operand latches are 0.
- Capture:
  - req_start[i]=1 at a rising edge sets pending[i] and latches operand_a[i] and operand_b[i].
  - If pending[i] is already set: the operands are dropped, the old request is kept, and overflow_err[i] is set. overflow_err clears only on reset.
- State machine:
  - ARB:
    - If any pending flag is set, pick the first pending requester at or after the pointer, wrapping modulo NUM_REQ.
    - On that edge: grant_id <= winner, unit operands <= its latched operands, unit_start <= 1, pending[winner] <= 0. Next state ISSUE.
  - ISSUE: unit_start <= 0. Next state WAIT.
  - WAIT:
    - On unit_result_ready=1: req_result <= unit_result, req_result_ready[grant_id] <= 1, pointer <= (grant_id+1) mod NUM_REQ. Next state ARB.
    - Otherwise remain in WAIT. There is no timeout.
  - In ARB, req_result_ready returns to 0.
- Latency:
  - A start sampled at edge t with the arbiter idle gives unit_start=1 during cycle t+1. ARB decides from the registered pending flags, so there is one cycle of capture latency.
  - unit_result_ready sampled at edge r gives req_result_ready during cycle r+1. The next unit_start can be asserted at the earliest in cycle r+2.
- unit_operand_a and unit_operand_b hold their values from the issue edge until the next issue.
- Simultaneous events:
  - If req_start[i] arrives on the same edge that pending[i] is granted and cleared, the set wins. The new request is captured with no overflow.
  - A start from the requester currently in flight is legal and is queued.
  - All requesters starting on the same edge are serviced in pointer order, one per operation.
- Spurious input: unit_result_ready in ARB or ISSUE is ignored and no req_result_ready is generated.
- busy = (state != ARB) | (|pending). It is combinational from registers.
- Reset mid-operation clears all state. An in-flight result arriving after reset is released is ignored (ARB state).
- Fairness: with all requesters continuously pending, grants rotate 0,1,...,NUM_REQ-1,0 and so on.

Decomposition:
- Package fp_arb_pkg:
  - typedef enum logic [1:0] {ARB, ISSUE, WAIT} arb_state_t;
  - localparam ARB_DEFAULT_NUM_REQ.
- Sub-module rr_priority_picker (combinational):
  - Inputs: pending vector, pointer.
  - Outputs: winner index and a found flag.
  - Implemented as a doubled-vector priority encoder.

Test Plan:
- Single request: req_start[1] with A=0x3F800000 and B=0x40000000, unit returns 0x40400000 after 4 cycles -> unit_start exactly 1 cycle after the start with those operands; req_result_ready=3'b010 for one cycle with req_result=0x40400000; busy falls the same cycle.
- Contention: all three requesters start on the same edge with distinct operands, pointer=0 -> unit issues requester 0, then 1, then 2; each req_result_ready is one-hot and carries the matching result; pointer returns to 0.
- Rotation: after requester 1 is served, requesters 0 and 2 start together -> requester 2 is granted first, then requester 0.
- Overflow: requester 0 starts twice while its first request is still pending -> overflow_err[0]=1; the first operands are issued; the second operands are never issued.
- Same-edge re-request: requester 2 starts on the edge its pending request is granted -> a second operation for requester 2 is issued after the first result; overflow_err stays 0.
- Reset mid-WAIT: reset=0 for 2 cycles while WAIT, then unit_result_ready pulses -> no req_result_ready; all outputs are 0; busy=0.
